ritc_phase_scanner_core: RTL
============================

# ritc_phase_scanner_core

Command-execution engine behind the RITC phase-scanner register interface. Consumes the interface's `cmd`/`select`/`argument` strobes, drives the MMCM dynamic phase-shift port and counts high samples of a selected RITC sample bit. Returns measurement results and closed-loop servo position to the interface's `result`/`servo` registers.

## Interface
- `WIN_DEFAULT`, 8: log2 measurement window after reset.
- `PS_TIMEOUT`, 1023: cycles to wait for `psdone_i` before aborting a shift step.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `cmd_i` in 8: opcode, valid with `cmd_wr_i`.
- `cmd_wr_i` in 1: one-cycle command strobe.
- `select_i` in 8: `[2:0]` picks bit of `sample_i`; `[7:3]` ignored.
- `argument_i` in 16: command argument, sampled with `cmd_wr_i`.
- `argument_wr_i` in 1: argument strobe; updates the servo target while the servo runs.
- `sample_i` in 8: RITC sample bits, already registered in the `CLK` domain.
- `psen_o` out 1: MMCM phase-shift enable, one-cycle pulse.
- `psincdec_o` out 1: 1 = increment, 0 = decrement; valid with `psen_o`.
- `psdone_i` in 1: MMCM shift-complete pulse.
- `result_o` out 16, `result_valid_o` out 1: command result and one-cycle strobe.
- `servo_o` out 16, `servo_update_o` out 1: signed phase position and one-cycle strobe.
- `busy_o` out 1: high whenever state is not IDLE.
- `err_o` out 1: sticky error; cleared by the next accepted command.

## Operation
- Opcodes:
  - 0x00 NOP.
  - 0x01 SET_WIN: `W = clamp(argument[3:0], 4, 15)`.
  - 0x02 SHIFT: signed `argument` steps.
  - 0x03 MEASURE.
  - 0x04 SERVO_ON: target = `argument`.
  - 0x05 SERVO_OFF.
  - Any other opcode: no-op, sets `err_o`.
- Commands are accepted only in IDLE. While busy, every command except SERVO_OFF is ignored and sets `err_o`.
- States: IDLE, SH_REQ, SH_WAIT, MEAS, SV_MEAS, SV_REQ, SV_WAIT.
- SHIFT:
  - Remaining = |arg|. Each step: SH_REQ pulses `psen_o` with `psincdec_o` = (arg>0); SH_WAIT waits for `psdone_i`.
  - On `psdone_i`: phase position ±1, remaining −1.
  - At remaining 0: `result_o` = phase position, strobe, IDLE.
  - arg = 0: result on the next cycle, no `psen_o`.
- MEASURE: counts cycles where `sample_i[select[2:0]]` = 1 over 2^W cycles. `result_o` = min(count, 0xFFFF).
- SERVO loop:
  - SV_MEAS performs one measurement.
  - count > target: shift −1. count < target: shift +1. Equal: no shift.
  - After the step (or immediately when equal): `servo_o` = position, `servo_update_o` pulses, `result_o` = count with `result_valid_o` pulsed, loop back to SV_MEAS.
- SERVO_OFF:
  - From SV_MEAS: abort immediately to IDLE.
  - From SV_REQ/SV_WAIT: finish the pending step (position and `servo_o` updated), then IDLE. A shift is never abandoned mid-flight.
- `argument_wr_i` in servo states replaces the target, effective at the next comparison.
- Phase position is 16-bit two's-complement and wraps (0x7FFF+1 → 0x8000).
- Timeout: `PS_TIMEOUT` cycles in SH_WAIT/SV_WAIT without `psdone_i` → `err_o` = 1, IDLE, no result strobe, position unchanged.
- A `psdone_i` outside a wait state is ignored.
- `select_i` is sampled once at measurement start.

## Timing
- Reset values:
  - All outputs 0: `result_o`, `result_valid_o`, `servo_o`, `servo_update_o`, `psen_o`, `psincdec_o`, `busy_o`, `err_o`.
  - W = `WIN_DEFAULT`, position 0, state IDLE.
- Asynchronous reset mid-operation aborts immediately. No `psen_o` is emitted after reset.
- Command sampled at edge E0; `busy_o` high from E1.
- MEASURE: samples at E1..E(2^W); `result_valid_o` high for the cycle after E(2^W+1).
- SHIFT: first `psen_o` at E1. The next `psen_o` comes 1 cycle after the `psdone_i` cycle.
- SET_WIN, NOP, and zero SHIFT: one busy cycle; `busy_o` low again at E2.
- `result_valid_o` and `servo_update_o` coincide in the servo loop.

## Structure
- Shared package `ritc_phase_scanner_pkg`:
  - Opcode localparams, state enum, W clamp bounds (4, 15).
- Sub-module `ritc_phase_ones_counter`:
  - Start/done handshake, 2^W window counter, 17-bit ones count, saturation to 16 bits, abort input.
- Top-level FSM handles the phase accumulator, timeout counter and strobes.

## Test plan
- Reset, SET_WIN 4, MEASURE with `sample_i[3]` tied 1 and `select` = 3 → `result_o` = 16 after 16 sample cycles; `busy_o` drops with the strobe.
- SHIFT −3 with `psdone_i` returned 5 cycles after each `psen_o` → 3 pulses with `psincdec_o` = 0, `result_o` = 0xFFFD.
- SET_WIN 15, `sample_i` all ones, MEASURE → `result_o` = 0x8000. SET_WIN 0 → W = 4 (16 cycles).
- SHIFT +1 with no `psdone_i` → `err_o` = 1 after 1023 cycles, no `result_valid_o`, position 0. The next NOP clears `err_o`.
- SERVO_ON target 8, W = 4, sample high 12/16 → `servo_o` steps −1 per iteration. `argument_wr_i` target 12 → `servo_update_o` with position unchanged.
- SERVO_OFF issued during SV_WAIT → step completes, `servo_update_o` pulses once, IDLE. MEASURE issued while busy → ignored, `err_o` = 1.

Source files
------------

// File: rtl/ritc_phase_scanner_pkg.sv
// Shared opcodes, FSM states and window bounds for the RITC phase-scanner command engine.
package ritc_phase_scanner_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_WIN   = 8'h01;
    localparam logic [7:0] OP_SHIFT     = 8'h02;
    localparam logic [7:0] OP_MEASURE   = 8'h03;
    localparam logic [7:0] OP_SERVO_ON  = 8'h04;
    localparam logic [7:0] OP_SERVO_OFF = 8'h05;

    localparam logic [3:0] WIN_MIN = 4'd4;
    localparam logic [3:0] WIN_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SH_REQ,
        ST_SH_WAIT,
        ST_MEAS,
        ST_SV_MEAS,
        ST_SV_REQ,
        ST_SV_WAIT
    } state_e;

    function automatic logic [3:0] clamp_win(input logic [3:0] req);
        logic [4:0] req5;
        req5 = {1'b0, req};
        if (req5 < {1'b0, WIN_MIN}) return WIN_MIN;
        if (req5 > {1'b0, WIN_MAX}) return WIN_MAX;
        return req;
    endfunction

endpackage

// File: rtl/ritc_phase_scanner_if.sv
// Register-side strobes and results exchanged between the register front end and the command engine.
interface ritc_phase_scanner_if;
    logic [7:0]  cmd_i;
    logic        cmd_wr_i;
    logic [7:0]  select_i;
    logic [15:0] argument_i;
    logic        argument_wr_i;
    logic [15:0] result_o;
    logic        result_valid_o;
    logic [15:0] servo_o;
    logic        servo_update_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output cmd_i, cmd_wr_i, select_i, argument_i, argument_wr_i,
        input  result_o, result_valid_o, servo_o, servo_update_o, busy_o, err_o
    );

    modport slave (
        input  cmd_i, cmd_wr_i, select_i, argument_i, argument_wr_i,
        output result_o, result_valid_o, servo_o, servo_update_o, busy_o, err_o
    );
endinterface

// File: rtl/ritc_phase_ones_counter.sv
// Counts high samples of one selected sample bit over a 2^W-cycle window; done pulses one cycle after the last sample.
module ritc_phase_ones_counter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [3:0]  win_i,
    input  logic [2:0]  sel_i,
    input  logic [7:0]  sample_i,
    output logic        done_o,
    output logic [15:0] count_o
);
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [16:0] ones_q, ones_d;

    always_comb begin
        active_d  = active_q;
        done_d    = 1'b0;
        win_cnt_d = win_cnt_q;
        sel_d     = sel_q;
        ones_d    = ones_q;
        if (abort_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            active_d  = 1'b1;
            win_cnt_d = 16'((17'd1 << win_i) - 17'd1);
            sel_d     = sel_i;
            ones_d    = '0;
        end else if (active_q) begin
            ones_d = ones_q + 17'(sample_i[sel_q]);
            if (win_cnt_q == '0) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                win_cnt_d = win_cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            win_cnt_q <= '0;
            sel_q     <= '0;
            ones_q    <= '0;
        end else begin
            active_q  <= active_d;
            done_q    <= done_d;
            win_cnt_q <= win_cnt_d;
            sel_q     <= sel_d;
            ones_q    <= ones_d;
        end
    end

    assign done_o  = done_q;
    assign count_o = ones_q[16] ? 16'hFFFF : ones_q[15:0];
endmodule

// File: rtl/ritc_phase_scanner_core.sv
// Command engine: phase-shift stepping, windowed ones measurement and a one-step-per-measurement servo loop.
//   state      | meaning
//   IDLE       | waiting for a command
//   SH_REQ     | issue one shift step (or finish a zero-length / housekeeping command)
//   SH_WAIT    | wait for psdone_i of the current SHIFT step
//   MEAS       | one-shot measurement in progress
//   SV_MEAS    | servo measurement in progress
//   SV_REQ     | issue the servo correction step
//   SV_WAIT    | wait for psdone_i of the servo step
module ritc_phase_scanner_core
    import ritc_phase_scanner_pkg::*;
#(
    parameter int WIN_DEFAULT = 8,
    parameter int PS_TIMEOUT  = 1023
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    ritc_phase_scanner_if.slave   bus,
    input  logic [7:0]            sample_i,
    output logic                  psen_o,
    output logic                  psincdec_o,
    input  logic                  psdone_i
);
    localparam logic [15:0] TMO_LOAD = 16'(PS_TIMEOUT - 1);
    localparam logic [3:0]  WIN_RST  = 4'(WIN_DEFAULT);

    state_e      state_q, state_d;
    logic [15:0] pos_q, pos_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] tmo_q, tmo_d;
    logic        dir_q, dir_d;
    logic        report_q, report_d;
    logic        off_q, off_d;
    logic [3:0]  win_q, win_d;
    logic [15:0] target_q, target_d;
    logic [15:0] meas_q, meas_d;
    logic [15:0] result_q, result_d;
    logic        rv_q, rv_d;
    logic [15:0] servo_q, servo_d;
    logic        su_q, su_d;
    logic        err_q, err_d;

    logic        off_req, meas_start, meas_abort, cnt_done;
    logic [15:0] cnt_val, arg_abs, pos_step;
    logic        sel_unused;

    assign off_req    = bus.cmd_wr_i && (bus.cmd_i == OP_SERVO_OFF);
    assign arg_abs    = bus.argument_i[15] ? 16'(-bus.argument_i) : bus.argument_i;
    assign pos_step   = dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
    assign meas_abort = (state_q == ST_SV_MEAS) && off_req;
    assign sel_unused = ^bus.select_i[7:3];

    ritc_phase_ones_counter u_ones (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start_i  (meas_start),
        .abort_i  (meas_abort),
        .win_i    (win_q),
        .sel_i    (bus.select_i[2:0]),
        .sample_i (sample_i),
        .done_o   (cnt_done),
        .count_o  (cnt_val)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.cmd_wr_i) begin
                if (bus.cmd_i == OP_MEASURE)       state_d = ST_MEAS;
                else if (bus.cmd_i == OP_SERVO_ON) state_d = ST_SV_MEAS;
                else                               state_d = ST_SH_REQ;
            end
            ST_SH_REQ:  state_d = (rem_q == '0) ? ST_IDLE : ST_SH_WAIT;
            ST_SH_WAIT: begin
                if (psdone_i)          state_d = (rem_q == 16'd1) ? ST_IDLE : ST_SH_REQ;
                else if (tmo_q == '0)  state_d = ST_IDLE;
            end
            ST_MEAS:    if (cnt_done) state_d = ST_IDLE;
            ST_SV_MEAS: begin
                if (off_req)       state_d = ST_IDLE;
                else if (cnt_done) state_d = (cnt_val == target_q) ? ST_SV_MEAS : ST_SV_REQ;
            end
            ST_SV_REQ:  state_d = ST_SV_WAIT;
            ST_SV_WAIT: begin
                if (psdone_i)          state_d = (off_q || off_req) ? ST_IDLE : ST_SV_MEAS;
                else if (tmo_q == '0)  state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pos_d = pos_q;   rem_d = rem_q;       tmo_d = tmo_q;       dir_d = dir_q;
        report_d = report_q; off_d = off_q;   win_d = win_q;       target_d = target_q;
        meas_d = meas_q; result_d = result_q; servo_d = servo_q;   err_d = err_q;
        rv_d = 1'b0;
        su_d = 1'b0;
        psen_o = ((state_q == ST_SH_REQ) && (rem_q != '0)) || (state_q == ST_SV_REQ);
        psincdec_o = psen_o && dir_q;
        // A back-to-back servo measurement restarts on the same edge that consumes the previous count.
        meas_start = ((state_q == ST_IDLE) && (state_d == ST_MEAS)) ||
                     ((state_d == ST_SV_MEAS) && ((state_q != ST_SV_MEAS) || cnt_done));

        if (state_q != ST_IDLE && bus.cmd_wr_i && bus.cmd_i != OP_SERVO_OFF) err_d = 1'b1;
        if ((state_q == ST_SV_MEAS || state_q == ST_SV_REQ || state_q == ST_SV_WAIT) && bus.argument_wr_i)
            target_d = bus.argument_i;

        unique case (state_q)
            ST_IDLE: if (bus.cmd_wr_i) begin
                err_d    = (bus.cmd_i > OP_SERVO_OFF);
                report_d = (bus.cmd_i == OP_SHIFT);
                rem_d    = '0;
                if (bus.cmd_i == OP_SHIFT) begin
                    rem_d = arg_abs;
                    dir_d = !bus.argument_i[15] && (bus.argument_i != '0);
                end
                if (bus.cmd_i == OP_SET_WIN) win_d = clamp_win(bus.argument_i[3:0]);
                if (bus.cmd_i == OP_SERVO_ON) begin
                    target_d = bus.argument_i;
                    off_d    = 1'b0;
                end
            end
            ST_SH_REQ: begin
                tmo_d = TMO_LOAD;
                if (rem_q == '0 && report_q) begin
                    result_d = pos_q;
                    rv_d     = 1'b1;
                end
            end
            ST_SH_WAIT, ST_SV_WAIT: begin
                if (state_q == ST_SV_WAIT && off_req) off_d = 1'b1;
                if (psdone_i) begin
                    pos_d = pos_step;
                    rem_d = rem_q - 16'd1;
                    if (state_q == ST_SV_WAIT) begin
                        servo_d  = pos_step;
                        su_d     = 1'b1;
                        result_d = meas_q;
                        rv_d     = 1'b1;
                    end else if (rem_q == 16'd1) begin
                        result_d = pos_step;
                        rv_d     = 1'b1;
                    end
                end else if (tmo_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            ST_MEAS: if (cnt_done) begin
                result_d = cnt_val;
                rv_d     = 1'b1;
            end
            ST_SV_MEAS: if (!off_req && cnt_done) begin
                meas_d = cnt_val;
                dir_d  = (cnt_val < target_q);
                if (cnt_val == target_q) begin
                    servo_d  = pos_q;
                    su_d     = 1'b1;
                    result_d = cnt_val;
                    rv_d     = 1'b1;
                end
            end
            ST_SV_REQ: begin
                tmo_d = TMO_LOAD;
                if (off_req) off_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos_q <= '0;  rem_q <= '0;  tmo_q <= '0;  dir_q <= 1'b0;
            report_q <= 1'b0;  off_q <= 1'b0;  win_q <= WIN_RST;  target_q <= '0;
            meas_q <= '0;  result_q <= '0;  rv_q <= 1'b0;  servo_q <= '0;
            su_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            pos_q <= pos_d;  rem_q <= rem_d;  tmo_q <= tmo_d;  dir_q <= dir_d;
            report_q <= report_d;  off_q <= off_d;  win_q <= win_d;  target_q <= target_d;
            meas_q <= meas_d;  result_q <= result_d;  rv_q <= rv_d;  servo_q <= servo_d;
            su_q <= su_d;  err_q <= err_d;
        end
    end

    assign bus.result_o       = result_q;
    assign bus.result_valid_o = rv_q;
    assign bus.servo_o        = servo_q;
    assign bus.servo_update_o = su_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.err_o          = err_q;
endmodule
